// File: rtl/fifo_checker.sv
// Streaming FIFO data checker: reads packets from an upstream FIFO and compares each word
// against an incrementing (or fixed) pattern. Define FIFO_CHECKER_TIMEOUT_EN to add stall abort.
module fifo_checker #(
    parameter int TBYTE_NUM      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            trans_len,
    input  logic [31:0]            pkt_len,
    input  logic [31:0]            rd_gap,
    input  logic [TBYTE_NUM*8-1:0] start_from,
    input  logic [TBYTE_NUM*8-1:0] inc,
    input  logic                   fix,
    input  logic                   check_start,
    output logic                   check_busy,
    output logic                   check_done,
    output logic                   fifo_rd,
    input  logic                   fifo_empty,
    input  logic [TBYTE_NUM*8-1:0] fifo_dout,
    output logic [31:0]            word_cnt,
    output logic [31:0]            err_cnt,
    output logic [TBYTE_NUM*8-1:0] first_err_data,
    output logic [TBYTE_NUM*8-1:0] first_err_exp,
    output logic                   timeout
);

    localparam int W = TBYTE_NUM * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            return val;
        end else begin
            return val + 32'd1;
        end
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [31:0]    gap_r;
    logic [31:0]    gap_nxt_s;
    logic           fifo_rd_r;
    logic           busy_r;
    logic           done_r;

    logic [31:0]    trans_len_r;
    logic [31:0]    pkt_len_r;
    logic [31:0]    rd_gap_r;
    logic [W-1:0]   start_from_r;
    logic [W-1:0]   inc_r;
    logic           fix_r;

    logic [31:0]    beat_cnt_r;
    logic [31:0]    pkt_cnt_r;
    logic [W-1:0]   exp_r;
    logic [W-1:0]   exp_pipe_r;
    logic           cmp_valid_r;
    logic [31:0]    word_cnt_r;
    logic [31:0]    err_cnt_r;
    logic [W-1:0]   first_err_data_r;
    logic [W-1:0]   first_err_exp_r;

    logic           start_s;
    logic           rd_acc_s;
    logic           last_beat_s;
    logic           last_word_s;
    logic           mismatch_s;
    logic           stall_hit_s;

    assign start_s     = (state_r == ST_IDLE) && check_start;
    assign rd_acc_s    = fifo_rd_r && !fifo_empty;
    assign last_beat_s = (beat_cnt_r == (trans_len_r - 32'd1));
    assign last_word_s = last_beat_s && (pkt_cnt_r == (pkt_len_r - 32'd1));
    assign mismatch_s  = cmp_valid_r && (fifo_dout != exp_pipe_r);

`ifdef FIFO_CHECKER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0]    stall_r;
    logic           timeout_r;

    assign stall_hit_s = (state_r == ST_RUN) && fifo_rd_r && fifo_empty && (stall_r == TMO_LAST);

    // Stall counter: consecutive read attempts refused by an empty source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_r   <= 32'd0;
            timeout_r <= 1'b0;
        end else if (start_s) begin
            stall_r   <= 32'd0;
            timeout_r <= 1'b0;
        end else if (rd_acc_s) begin
            stall_r   <= 32'd0;
        end else if ((state_r == ST_RUN) && fifo_rd_r && fifo_empty) begin
            stall_r   <= stall_r + 32'd1;
            if (stall_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    logic unused_tmo_s;

    assign unused_tmo_s = (TIMEOUT_CYCLES == 0);
    assign stall_hit_s  = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Next-state and read-gap decode.
    always_comb begin
        state_nxt_s = state_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (check_start) begin
                    gap_nxt_s = 32'd0;
                    if ((trans_len == 32'd0) || (pkt_len == 32'd0)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_acc_s) begin
                    gap_nxt_s = rd_gap_r;
                    if (last_word_s) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (stall_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                    if (gap_r != 32'd0) begin
                        gap_nxt_s = gap_r - 32'd1;
                    end else begin
                        gap_nxt_s = gap_r;
                    end
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; handshake outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gap_r     <= 32'd0;
            fifo_rd_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gap_r     <= gap_nxt_s;
            fifo_rd_r <= (state_nxt_s == ST_RUN) && (gap_nxt_s == 32'd0);
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // Configuration latch, expected-pattern generator, compare pipeline and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans_len_r      <= 32'd0;
            pkt_len_r        <= 32'd0;
            rd_gap_r         <= 32'd0;
            start_from_r     <= '0;
            inc_r            <= '0;
            fix_r            <= 1'b0;
            beat_cnt_r       <= 32'd0;
            pkt_cnt_r        <= 32'd0;
            exp_r            <= '0;
            exp_pipe_r       <= '0;
            cmp_valid_r      <= 1'b0;
            word_cnt_r       <= 32'd0;
            err_cnt_r        <= 32'd0;
            first_err_data_r <= '0;
            first_err_exp_r  <= '0;
        end else if (start_s) begin
            trans_len_r      <= trans_len;
            pkt_len_r        <= pkt_len;
            rd_gap_r         <= rd_gap;
            start_from_r     <= start_from;
            inc_r            <= inc;
            fix_r            <= fix;
            beat_cnt_r       <= 32'd0;
            pkt_cnt_r        <= 32'd0;
            exp_r            <= start_from;
            cmp_valid_r      <= 1'b0;
            word_cnt_r       <= 32'd0;
            err_cnt_r        <= 32'd0;
            first_err_data_r <= '0;
            first_err_exp_r  <= '0;
        end else begin
            cmp_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                exp_pipe_r <= exp_r;
                word_cnt_r <= word_cnt_r + 32'd1;
                if (last_beat_s) begin
                    beat_cnt_r <= 32'd0;
                    pkt_cnt_r  <= pkt_cnt_r + 32'd1;
                    exp_r      <= start_from_r;
                end else begin
                    beat_cnt_r <= beat_cnt_r + 32'd1;
                    exp_r      <= fix_r ? start_from_r : (exp_r + inc_r);
                end
            end
            if (mismatch_s) begin
                err_cnt_r <= sat_inc32(err_cnt_r);
                if (err_cnt_r == 32'd0) begin
                    first_err_data_r <= fifo_dout;
                    first_err_exp_r  <= exp_pipe_r;
                end
            end
        end
    end

    assign fifo_rd        = fifo_rd_r;
    assign check_busy     = busy_r;
    assign check_done     = done_r;
    assign word_cnt       = word_cnt_r;
    assign err_cnt        = err_cnt_r;
    assign first_err_data = first_err_data_r;
    assign first_err_exp  = first_err_exp_r;

endmodule

// File: tb/tb_fifo_checker.sv
// Self-checking bench for fifo_checker: a FIFO source model feeds words on accepted reads and
// a scoreboard of expected err_cnt values is checked one cycle after each word is delivered.
module tb_fifo_checker;

    localparam int TB_BYTES = 16;
    localparam int W        = TB_BYTES * 8;
    localparam int TMO      = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   trans_len = '0;
    logic [31:0]   pkt_len = '0;
    logic [31:0]   rd_gap = '0;
    logic [W-1:0]  start_from = '0;
    logic [W-1:0]  inc = '0;
    logic          fix = 1'b0;
    logic          check_start = 1'b0;
    logic          check_busy;
    logic          check_done;
    logic          fifo_rd;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_dout = '0;
    logic [31:0]   word_cnt;
    logic [31:0]   err_cnt;
    logic [W-1:0]  first_err_data;
    logic [W-1:0]  first_err_exp;
    logic          timeout;

    always #5 clk = ~clk;

    fifo_checker #(
        .TBYTE_NUM      (TB_BYTES),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trans_len      (trans_len),
        .pkt_len        (pkt_len),
        .rd_gap         (rd_gap),
        .start_from     (start_from),
        .inc            (inc),
        .fix            (fix),
        .check_start    (check_start),
        .check_busy     (check_busy),
        .check_done     (check_done),
        .fifo_rd        (fifo_rd),
        .fifo_empty     (fifo_empty),
        .fifo_dout      (fifo_dout),
        .word_cnt       (word_cnt),
        .err_cnt        (err_cnt),
        .first_err_data (first_err_data),
        .first_err_exp  (first_err_exp),
        .timeout        (timeout)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   sb_q[$];
    int            acc_cyc_q[$];
    int            done_pulses;
    int            done_cyc;
    bit            rd_seen;
    logic [31:0]   m_err;
    logic [W-1:0]  m_first_data;
    logic [W-1:0]  m_first_exp;

    // Starts one run and plays the FIFO source until the run ends or the cycle budget expires.
    task automatic drive_run(input int tl, input int pl, input int gap,
                             input logic [W-1:0] sf, input logic [W-1:0] ic, input bit fx,
                             input int bad_idx, input logic [W-1:0] bad_val,
                             input bit starve, input bit jitter, input int budget);
        int           sent;
        int           issued;
        int           beat;
        bit           acc_prev;
        logic [W-1:0] m_exp;
        logic [W-1:0] word;
        logic [31:0]  sb_exp;
        trans_len   = tl;
        pkt_len     = pl;
        rd_gap      = gap;
        start_from  = sf;
        inc         = ic;
        fix         = fx;
        fifo_empty  = 1'b1;
        check_start = 1'b1;
        @(negedge clk);
        check_start = 1'b0;
        m_exp = sf; m_err = '0; m_first_data = '0; m_first_exp = '0;
        sent = 0; issued = 0; beat = 0; acc_prev = 1'b0;
        done_pulses = 0; done_cyc = -1; rd_seen = 1'b0;
        sb_q.delete();
        acc_cyc_q.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (sb_q.size() > 0) begin
                sb_exp = sb_q.pop_front();
                n_tests++;
                if (err_cnt !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_err_cnt word %0d: got %0d expected %0d", sent - 1, err_cnt, sb_exp);
                end
            end
            if (check_done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (fifo_rd) rd_seen = 1'b1;
            if (acc_prev) begin
                word = (sent == bad_idx) ? bad_val : m_exp;
                fifo_dout = word;
                if (word !== m_exp) begin
                    if (m_err == 32'd0) begin
                        m_first_data = word;
                        m_first_exp  = m_exp;
                    end
                    m_err = m_err + 32'd1;
                end
                sb_q.push_back(m_err);
                sent++;
                beat++;
                if (beat == tl) begin
                    beat  = 0;
                    m_exp = sf;
                end else if (!fx) begin
                    m_exp = m_exp + ic;
                end
            end
            if (starve || issued >= tl * pl) fifo_empty = 1'b1;
            else fifo_empty = jitter && ($urandom_range(0, 2) == 0);
            acc_prev = fifo_rd && !fifo_empty;
            if (acc_prev) begin
                issued++;
                acc_cyc_q.push_back(cyc);
            end
            if (done_pulses > 0 && !check_busy) break;
            @(negedge clk);
        end
        fifo_empty = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({fifo_rd, check_busy, check_done, timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rd/busy/done/tmo=%b expected 0000",
                     {fifo_rd, check_busy, check_done, timeout});
        end
        n_tests++;
        if (word_cnt !== 32'd0 || err_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got word=%0d err=%0d expected 0/0", word_cnt, err_cnt);
        end
        n_tests++;
        if (first_err_data !== '0 || first_err_exp !== '0) begin
            n_fail++;
            $display("FAIL reset_first_err: got %h/%h expected 0/0", first_err_data, first_err_exp);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal(input string tag);
        drive_run(4, 2, 0, 128'h10, 128'h1, 1'b0, -1, '0, 1'b0, 1'b1, 300);
        n_tests++;
        if (word_cnt !== 32'd8) begin
            n_fail++; $display("FAIL %s_word_cnt: got %0d expected 8", tag, word_cnt);
        end
        n_tests++;
        if (err_cnt !== 32'd0) begin
            n_fail++; $display("FAIL %s_err_cnt: got %0d expected 0", tag, err_cnt);
        end
        n_tests++;
        if (done_pulses !== 1 || check_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_done: got pulses=%0d busy=%b expected 1/0", tag, done_pulses, check_busy);
        end
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL %s_timeout: got %b expected 0", tag, timeout);
        end
    endtask

    task automatic test_corrupt();
        drive_run(4, 2, 0, 128'h10, 128'h1, 1'b0, 2, 128'h13, 1'b0, 1'b1, 300);
        n_tests++;
        if (err_cnt !== 32'd1 || word_cnt !== 32'd8) begin
            n_fail++; $display("FAIL corrupt_cnt: got err=%0d word=%0d expected 1/8", err_cnt, word_cnt);
        end
        n_tests++;
        if (first_err_data !== 128'h13) begin
            n_fail++; $display("FAIL corrupt_first_data: got %h expected 13", first_err_data);
        end
        n_tests++;
        if (first_err_exp !== 128'h12) begin
            n_fail++; $display("FAIL corrupt_first_exp: got %h expected 12", first_err_exp);
        end
    endtask

    task automatic test_throttle();
        drive_run(4, 2, 2, 128'h40, 128'h3, 1'b0, -1, '0, 1'b0, 1'b0, 300);
        n_tests++;
        if (acc_cyc_q.size() != 8 || err_cnt !== 32'd0) begin
            n_fail++; $display("FAIL throttle_reads: got %0d reads err=%0d expected 8/0", acc_cyc_q.size(), err_cnt);
        end
        for (int i = 1; i < acc_cyc_q.size(); i++) begin
            n_tests++;
            if (acc_cyc_q[i] - acc_cyc_q[i-1] != 3) begin
                n_fail++;
                $display("FAIL throttle_gap %0d: got %0d cycles expected 3", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
            end
        end
    endtask

    task automatic test_fix();
        drive_run(3, 1, 0, 128'hA5, 128'h1, 1'b1, -1, '0, 1'b0, 1'b1, 200);
        n_tests++;
        if (err_cnt !== 32'd0 || word_cnt !== 32'd3) begin
            n_fail++; $display("FAIL fix_clean: got err=%0d word=%0d expected 0/3", err_cnt, word_cnt);
        end
        drive_run(3, 1, 0, 128'hA5, 128'h1, 1'b1, 1, 128'hA6, 1'b0, 1'b1, 200);
        n_tests++;
        if (err_cnt !== 32'd1 || first_err_exp !== 128'hA5 || first_err_data !== 128'hA6) begin
            n_fail++;
            $display("FAIL fix_bad: got err=%0d data=%h exp=%h expected 1/a6/a5", err_cnt, first_err_data, first_err_exp);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] sf;
        sf = {W{1'b1}};
        drive_run(3, 2, 1, sf, 128'h2, 1'b0, 4, 128'h5, 1'b0, 1'b1, 300);
        n_tests++;
        if (err_cnt !== 32'd1 || first_err_exp !== 128'h1 || first_err_data !== 128'h5) begin
            n_fail++;
            $display("FAIL wrap: got err=%0d exp=%h data=%h expected 1/1/5", err_cnt, first_err_exp, first_err_data);
        end
        n_tests++;
        if (first_err_exp !== m_first_exp || err_cnt !== m_err) begin
            n_fail++; $display("FAIL wrap_model: got exp=%h err=%0d expected %h/%0d", first_err_exp, err_cnt, m_first_exp, m_err);
        end
    endtask

    task automatic test_degenerate();
        drive_run(0, 2, 0, 128'h10, 128'h1, 1'b0, -1, '0, 1'b0, 1'b0, 20);
        n_tests++;
        if (rd_seen || done_pulses != 1 || done_cyc < 0 || done_cyc > 2) begin
            n_fail++; $display("FAIL degen_tl0: got rd=%b pulses=%0d at %0d expected 0/1/<=2", rd_seen, done_pulses, done_cyc);
        end
        drive_run(5, 0, 0, 128'h10, 128'h1, 1'b0, -1, '0, 1'b0, 1'b0, 20);
        n_tests++;
        if (rd_seen || done_pulses != 1 || done_cyc < 0 || done_cyc > 2) begin
            n_fail++; $display("FAIL degen_pl0: got rd=%b pulses=%0d at %0d expected 0/1/<=2", rd_seen, done_pulses, done_cyc);
        end
    endtask

    task automatic test_stall();
        drive_run(4, 2, 0, 128'h10, 128'h1, 1'b0, -1, '0, 1'b1, 1'b0, 40);
`ifdef FIFO_CHECKER_TIMEOUT_EN
        n_tests++;
        if (done_pulses != 1 || done_cyc != TMO || timeout !== 1'b1) begin
            n_fail++; $display("FAIL stall_timeout: got pulses=%0d at %0d tmo=%b expected 1/%0d/1", done_pulses, done_cyc, timeout, TMO);
        end
`else
        n_tests++;
        if (done_pulses != 0 || check_busy !== 1'b1 || fifo_rd !== 1'b1 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL stall_wait: got pulses=%0d busy=%b rd=%b tmo=%b expected 0/1/1/0", done_pulses, check_busy, fifo_rd, timeout);
        end
`endif
        n_tests++;
        if (word_cnt !== 32'd0) begin
            n_fail++; $display("FAIL stall_word_cnt: got %0d expected 0", word_cnt);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        pulses = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({fifo_rd, check_busy, check_done, timeout} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_ctrl: got rd/busy/done/tmo=%b expected 0000", {fifo_rd, check_busy, check_done, timeout});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (check_done) pulses++;
        end
        n_tests++;
        if (pulses != 0 || check_busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_done: got pulses=%0d busy=%b expected 0/0", pulses, check_busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal("nominal");
        test_corrupt();
        test_throttle();
        test_fix();
        test_wrap();
        test_degenerate();
        test_stall();
        test_reset_abort();
        test_nominal("restart");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_checker.md
FIFO_CHECKER -- requirements
Module: fifo_checker

Interface
REQ-001 SHALL have parameter TBYTE_NUM, default 16, data width in bytes (data width W = TBYTE_NUM*8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall limit in cycles; used only with FIFO_CHECKER_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port trans_len  input  32  words per packet.
REQ-006 SHALL have port pkt_len  input  32  packets per run.
REQ-007 SHALL have port rd_gap  input  32  idle cycles forced after each accepted read.
REQ-008 SHALL have port start_from  input  W  expected first word of every packet.
REQ-009 SHALL have port inc  input  W  expected increment per word.
REQ-010 SHALL have port fix  input  1  1 = every expected word equals start_from.
REQ-011 SHALL have port check_start  input  1  single-cycle run request.
REQ-012 SHALL have port check_busy  output  1  run in progress.
REQ-013 SHALL have port check_done  output  1  one-cycle pulse at run end.
REQ-014 SHALL have port fifo_rd  output  1  read strobe to upstream FIFO source.
REQ-015 SHALL have port fifo_empty  input  1  upstream FIFO has no data.
REQ-016 SHALL have port fifo_dout  input  W  read data, valid the cycle after an accepted read.
REQ-017 SHALL have port word_cnt  output  32  words accepted this run.
REQ-018 SHALL have port err_cnt  output  32  mismatched words this run.
REQ-019 SHALL have ports first_err_data and first_err_exp  output  W each  received and expected value of the first mismatch.
REQ-020 SHALL have port timeout  output  1  run aborted on stall.

Function
REQ-021 SHALL define accepted read = fifo_rd & ~fifo_empty; fifo_rd is asserted regardless of fifo_empty.
REQ-022 SHALL implement states IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-023 IDLE: on check_start, latch all configuration inputs, clear word_cnt, err_cnt, first_err_*, timeout, and enter RUN next cycle; check_start is ignored outside IDLE.
REQ-024 IDLE with latched trans_len==0 or pkt_len==0 SHALL go to DONE, never asserting fifo_rd.
REQ-025 RUN: fifo_rd = 1 when gap counter is 0; each accepted read loads gap counter with rd_gap, which decrements to 0 while fifo_rd = 0.
REQ-026 Expected value register SHALL start at start_from, advance by inc (mod 2^W) per accepted read, hold start_from when fix=1, and reload start_from after the last word of each packet.
REQ-027 On accepted read, the current expected value SHALL be pipelined one cycle and compared with fifo_dout in the following cycle (1-cycle compare latency).
REQ-028 On mismatch, err_cnt SHALL increment (saturating at 0xFFFFFFFF), and first_err_data/first_err_exp SHALL be captured only when err_cnt was 0.
REQ-029 word_cnt SHALL increment per accepted read, wrapping at 2^32.
REQ-030 Accepted read of word trans_len-1 of packet pkt_len-1 SHALL move RUN -> FLUSH; FLUSH lasts 1 cycle to finish the last compare, then DONE.
REQ-031 DONE SHALL last 1 cycle with check_done=1, then IDLE; check_busy = 1 in RUN, FLUSH, DONE.

Reset
REQ-032 rst SHALL asynchronously force IDLE, fifo_rd=0, check_busy=0, check_done=0, timeout=0, and all counters and captured values to 0.
REQ-033 rst asserted mid-run SHALL abort without a check_done pulse; the next check_start begins a clean run.

Configuration
REQ-034 With FIFO_CHECKER_TIMEOUT_EN defined, a stall counter SHALL count RUN cycles with fifo_rd & fifo_empty, clear on accepted read, and on reaching TIMEOUT_CYCLES set timeout=1 and go to DONE.
REQ-035 Without FIFO_CHECKER_TIMEOUT_EN, no stall counter SHALL exist, timeout SHALL be tied 0, and RUN waits indefinitely.

Verification
REQ-036 Nominal: trans_len=4, pkt_len=2, start_from=0x10, inc=1, fix=0, rd_gap=0, matching source -> word_cnt=8, err_cnt=0, one check_done pulse, check_busy returns to 0.
REQ-037 Corruption: same setup, 3rd word sent as 0x13 -> err_cnt=1, first_err_data=0x13, first_err_exp=0x12.
REQ-038 Throttle: rd_gap=2, source never empty -> accepted reads spaced exactly 3 cycles apart.
REQ-039 Fix mode: fix=1, start_from=0xA5, trans_len=3, pkt_len=1 -> three 0xA5 words give err_cnt=0; a 0xA6 word gives err_cnt=1.
REQ-040 Degenerate: trans_len=0 -> fifo_rd never asserted, check_done within 3 cycles of check_start.
REQ-041 Stall: fifo_empty held 1, TIMEOUT_CYCLES=16 -> with macro, timeout=1 and check_done after 16 stall cycles; without macro, check_busy stays 1 until rst.
